// File: rtl/ssriscv_fetch_ctrl.sv
// ssriscv_fetch_ctrl: instruction fetch sequencer for the single-issue core.
// Owns the architectural PC and issues one imem request per instruction.
// It latches the fetched word and holds it until execute commits, then loads
// the next PC. Misaligned targets park the core in FAULT until reset.
// Also handles the halt request and the retired-instruction counter.
module ssriscv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory request / response
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    // decode / execute side
    output logic [31:0] pc_now,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        commit,
    input  logic [31:0] pc_next,
    // control and status
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;

    // A committed target is accepted only if it is word aligned.
    logic target_misaligned;
    assign target_misaligned = (pc_next[1:0] != 2'b00);

    // Next-state and datapath update; every register holds unless its state acts on it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        instret_d  = instret_q;
        misalign_d = misalign_q;
        case (state_q)
            // One-cycle settle after reset; halt_req is sampled here.
            S_IDLE: begin
                state_d = halt_req ? S_HALT : S_REQ;
            end
            // Request held with a stable address until memory accepts it.
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            // Outstanding request: wait as long as it takes, halt cannot abandon it.
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            // Instruction presented to execute; pc_next only matters on commit.
            S_EXEC: begin
                if (commit) begin
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_FAULT;
                    end else begin
                        pc_d      = pc_next;
                        instret_d = instret_q + 32'd1;
                        state_d   = halt_req ? S_HALT : S_REQ;
                    end
                end
            end
            // Parked; resumes by fetching the already-loaded pc_now.
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_REQ;
                end
            end
            // Terminal until reset.
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0000_0000;
            instret_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs are either registers or pure decodes of the current state.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc_now         = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = (state_q == S_EXEC);
    assign halted         = (state_q == S_HALT);
    assign misalign       = misalign_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_ssriscv_fetch_ctrl.sv
// Randomized bench for ssriscv_fetch_ctrl. The driver runs the memory and
// execute sides; a reference model tracks PC / retire count / fault at the
// level of "what should have happened to the program", and expected fetch
// addresses and instruction words go into queues that a negedge monitor pops.
module tb_ssriscv_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_now;
    logic [31:0] inst;
    logic        inst_valid;
    logic        commit;
    logic [31:0] pc_next;
    logic        halt_req;
    logic        halted;
    logic        misalign;
    logic [31:0] instret;

    ssriscv_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .pc_now         (pc_now),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .commit         (commit),
        .pc_next        (pc_next),
        .halt_req       (halt_req),
        .halted         (halted),
        .misalign       (misalign),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    // reference model of the architectural effect of each commit
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_commit(input logic [31:0] target);
        if (target % 4 != 0) begin
            m_mis = 1'b1;
        end else begin
            m_pc  = target;
            m_ret = m_ret + 32'd1;
            exp_addr_q.push_back(target);
        end
    endfunction

    // monitor: compare every accepted request and every newly presented instruction
    logic prev_iv = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (inst_valid && !prev_iv) begin
                if (exp_inst_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_inst: got %h expected no instruction", inst);
                end else begin
                    chk("inst", inst, exp_inst_q.pop_front());
                end
            end
        end
        prev_iv = inst_valid;
    end

    task automatic do_reset(input logic h);
        rst = 1'b1;
        halt_req = h;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        commit = 1'b0;
        exp_addr_q.delete();
        exp_inst_q.delete();
        step();
        step();
        chk("rst_pc", pc_now, RESET_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_1bit", {28'h0, imem_req_valid, inst_valid, halted, misalign}, 32'h0);
        m_pc  = RESET_PC;
        m_ret = 32'h0;
        m_mis = 1'b0;
        if (!h) exp_addr_q.push_back(RESET_PC);
        rst = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {31'h0, imem_req_valid}, 32'h1);
    endtask

    // one full instruction: request, response, commit; checks the architectural result
    task automatic do_fetch(input logic [31:0] rdata, input logic [31:0] target, input logic h);
        wait_req();
        repeat ($urandom_range(0, 2)) step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
        repeat ($urandom_range(0, 3)) step();
        imem_rsp_valid = 1'b1;
        imem_rdata = rdata;
        exp_inst_q.push_back(rdata);
        step();
        imem_rsp_valid = 1'b0;
        imem_rdata = $urandom;
        chk("exec_iv", {31'h0, inst_valid}, 32'h1);
        repeat ($urandom_range(0, 2)) step();
        commit = 1'b1;
        pc_next = target;
        halt_req = h;
        model_commit(target);
        step();
        commit = 1'b0;
        pc_next = $urandom;
        chk("pc_now", pc_now, m_pc);
        chk("instret", instret, m_ret);
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
        chk("halted", {31'h0, halted}, {31'h0, h & ~m_mis});
    endtask

    task automatic hold_halt(input int cycles);
        repeat (cycles) begin
            step();
            chk("halt_hold", {30'h0, halted, imem_req_valid}, 32'h2);
        end
        halt_req = 1'b0;
        step();
        chk("halt_exit_req", {31'h0, imem_req_valid}, 32'h1);
        chk("halt_exit_addr", imem_addr, m_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata = 32'h0;
        commit = 1'b0;
        pc_next = 32'h0;
        halt_req = 1'b0;

        do_reset(1'b0);

        // request held with stable address while ready is low; commit outside EXEC ignored
        commit = 1'b1;
        pc_next = 32'h40;
        repeat (5) begin
            step();
            chk("stall_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("stall_addr", imem_addr, RESET_PC);
        end
        commit = 1'b0;
        chk("stray_commit_pc", pc_now, m_pc);
        chk("stray_commit_ret", instret, m_ret);

        // basic fetch: nop, next PC 0x4
        do_fetch(32'h0000_0013, 32'h0000_0004, 1'b0);

        // randomized program flow with occasional halts
        for (int i = 0; i < 15; i++) begin
            logic hh;
            hh = ($urandom_range(0, 4) == 0);
            do_fetch($urandom, $urandom & 32'hFFFF_FFFC, hh);
            if (hh) hold_halt($urandom_range(1, 3));
        end

        // halt at commit with target 0x8
        do_fetch($urandom, 32'h0000_0008, 1'b1);
        chk("halt_pc", pc_now, 32'h8);
        hold_halt(4);

        // retire counter wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        step();
        release dut.instret_q;
        m_ret = 32'hFFFF_FFFF;
        chk("preload_ret", instret, 32'hFFFF_FFFF);
        do_fetch($urandom, 32'h0000_0100, 1'b0);
        chk("wrap_ret", instret, 32'h0);

        // misaligned target: sticky fault, no requests, commits ignored
        do_fetch($urandom, 32'h0000_0102, 1'b0);
        imem_req_ready = 1'b1;
        commit = 1'b1;
        pc_next = 32'h200;
        repeat (5) begin
            step();
            chk("fault_quiet", {29'h0, imem_req_valid, inst_valid, misalign}, 32'h1);
            chk("fault_pc", pc_now, m_pc);
        end
        imem_req_ready = 1'b0;
        commit = 1'b0;
        do_reset(1'b0);
        do_fetch($urandom, 32'h0000_0010, 1'b0);

        // reset while a response is outstanding; late response is ignored
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        exp_addr_q.delete();
        exp_inst_q.delete();
        chk("midrst_state", {30'h0, imem_req_valid, inst_valid}, 32'h0);
        chk("midrst_pc", pc_now, RESET_PC);
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        m_pc = RESET_PC;
        m_ret = 32'h0;
        m_mis = 1'b0;
        exp_addr_q.push_back(RESET_PC);
        rst = 1'b0;
        step();
        step();
        chk("late_rsp_inst", inst, 32'h0);
        chk("late_rsp_state", {30'h0, imem_req_valid, inst_valid}, 32'h2);
        imem_rsp_valid = 1'b0;
        do_fetch($urandom, 32'h0000_0020, 1'b0);

        // halt requested across reset release: IDLE goes straight to HALT
        do_reset(1'b1);
        step();
        chk("idle_halt", {30'h0, halted, imem_req_valid}, 32'h2);
        exp_addr_q.push_back(RESET_PC);
        hold_halt(2);
        do_fetch($urandom, 32'h0000_0004, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
